// File: rtl/cam_frame_writer.sv
// cam_frame_writer
//   Write-side front end of the VGA frame buffer. Takes a camera RGB565 byte
//   stream (vsync / href / byte strobe, already synchronous to clk), reduces
//   each pixel to RGB111 by keeping the MSB of every channel, and writes the
//   pixels row-major into the buffer RAM write port. One frame of
//   CAM_SCREEN_X x CAM_SCREEN_Y pixels is stored per vsync period; surplus
//   pixels on a line and surplus lines in a frame are dropped.
//
// Ports
//   clk         system clock, the only clock
//   rst         synchronous, active-high reset
//   cam_vsync   frame sync, high between frames
//   cam_href    line valid, high while a line's bytes arrive
//   cam_de      one-cycle strobe per valid cam_data byte
//   cam_data    pixel byte: first {R[4:0],G[5:3]}, second {G[2:0],B[4:0]}
//   addr_in     buffer write address (held between writes)
//   data_in     buffer write data, RGB111 with R in bit 2 (held between writes)
//   regwrite    buffer write enable, one pulse per stored pixel
//   frame_done  one-cycle pulse when a captured frame is closed by vsync
module cam_frame_writer #(
  parameter int AW           = 8,
  parameter int DW           = 3,
  parameter int CAM_SCREEN_X = 16,
  parameter int CAM_SCREEN_Y = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic          cam_de,
  input  logic [7:0]    cam_data,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] x, y;
  logic          phase;
  logic [7:0]    byte0;
  logic          vsync_d, href_d;

  // Edge detection against the previous cycle's sampled inputs.
  logic vs_rise, vs_fall, href_fall;
  assign vs_rise   =  cam_vsync & ~vsync_d;
  assign vs_fall   = ~cam_vsync &  vsync_d;
  assign href_fall = ~cam_href  &  href_d;

  // FSM control decoded in the comb process.
  logic clr_cnt;   // start of a new frame: clear x, y, phase
  logic fd_nxt;    // frame_done for the next cycle
  logic capture;   // byte accepted this cycle

  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
    fd_nxt    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (vs_rise) state_nxt = SYNC;
      end
      SYNC: begin
        if (vs_fall) begin
          clr_cnt   = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          // Closing the frame takes priority over any byte on the same
          // cycle; a half pixel is lost because phase is cleared on vs_fall.
          fd_nxt    = 1'b1;
          state_nxt = SYNC;
        end else begin
          capture = cam_de & cam_href;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Pixel completion and window test. The window test uses int arithmetic
  // so that CAM_SCREEN_X / CAM_SCREEN_Y need not fit the AW-bit counters.
  logic px_done, in_win;
  assign px_done = capture & phase;
  assign in_win  = (int'(x) < CAM_SCREEN_X) && (int'(y) < CAM_SCREEN_Y);

  // Full-width address product, truncated to AW when registered.
  logic [31:0] wr_addr_full;
  assign wr_addr_full = 32'(int'(x) + int'(y) * CAM_SCREEN_X);

  // RGB565 -> RGB111: R msb from byte0[7], G msb from byte0[2],
  // B msb from the second byte's bit 4.
  logic [2:0] rgb;
  assign rgb = {byte0[7], byte0[2], cam_data[4]};

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_in    <= '0;
      data_in    <= '0;
      regwrite   <= 1'b0;
      frame_done <= 1'b0;
      x          <= '0;
      y          <= '0;
      phase      <= 1'b0;
      byte0      <= '0;
      vsync_d    <= 1'b0;
      href_d     <= 1'b0;
    end else begin
      vsync_d    <= cam_vsync;
      href_d     <= cam_href;
      regwrite   <= 1'b0;
      frame_done <= fd_nxt;

      if (clr_cnt) begin
        x     <= '0;
        y     <= '0;
        phase <= 1'b0;
      end else if (state == ACTIVE && !vs_rise) begin
        if (capture) begin
          if (!phase) begin
            byte0 <= cam_data;
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            // Out-of-window pixels are dropped; x stops at CAM_SCREEN_X.
            if (in_win) begin
              addr_in  <= wr_addr_full[AW-1:0];
              data_in  <= DW'(rgb);
              regwrite <= 1'b1;
              x        <= x + 1'b1;
            end
          end
        end

        if (href_fall) begin
          // Dangling first byte is discarded. Only lines that delivered at
          // least one complete pixel advance y; y saturates so that extra
          // lines stay outside the window.
          phase <= 1'b0;
          if (x != '0 || px_done) begin
            x <= '0;
            if (int'(y) < CAM_SCREEN_Y) y <= y + 1'b1;
          end
        end
      end
    end
  end

  // Bits that the RGB111 reduction deliberately throws away.
  logic unused_bits;
  assign unused_bits = ^{byte0[6:3], byte0[1:0], wr_addr_full[31:AW]};

endmodule

// File: tb/tb_cam_frame_writer.sv
module tb_cam_frame_writer;
  localparam int AW = 8;
  localparam int DW = 3;
  localparam int SX = 16;
  localparam int SY = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic          cam_de = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite;
  logic          frame_done;

  cam_frame_writer #(.AW(AW), .DW(DW), .CAM_SCREEN_X(SX), .CAM_SCREEN_Y(SY)) dut (
    .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_de(cam_de), .cam_data(cam_data), .addr_in(addr_in),
    .data_in(data_in), .regwrite(regwrite), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            done;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: whether a frame is being captured, whether a
  // vsync rise has armed the next frame, and the row the next line lands on.
  bit m_active = 0;
  bit m_armed  = 0;
  int m_row    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit de, input logic [7:0] d);
    cam_de   = de;
    cam_data = d;
    tick();
    cam_de   = 1'b0;
  endtask

  // Idle cycles; while href is low, random stray strobes must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(!cam_href && ($urandom_range(0, 3) == 0), 8'($urandom));
    end
  endtask

  task automatic vs_rise_ev();
    cam_vsync = 1'b1;
    if (m_active) q.push_back('{done: 1'b1, addr: '0, data: '0, cyc: cyc + 1});
    m_active = 0;
    m_armed  = 1;
    tick();
  endtask

  task automatic vs_fall_ev();
    cam_vsync = 1'b0;
    if (m_armed) begin
      m_active = 1;
      m_armed  = 0;
      m_row    = 0;
    end
    tick();
  endtask

  task automatic vsync_pulse();
    idle(2);
    vs_rise_ev();
    idle(3);
    vs_fall_ev();
    idle(3);
  endtask

  // One camera line of n complete pixels, an optional dangling first byte,
  // and optionally a vsync rise while href is still high.
  task automatic send_line(input int n, input bit half, input bit use_fixed,
                           input logic [15:0] fixed, input bit vs_mid);
    logic [15:0] p;
    cam_href = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      p = use_fixed ? fixed : 16'($urandom);
      drive(1'b1, p[15:8]);
      repeat ($urandom_range(0, 2)) drive(1'b0, 8'($urandom));
      if (m_active && m_row < SY && i < SX)
        q.push_back('{done: 1'b0, addr: AW'(m_row * SX + i),
                      data: {p[15], p[10], p[4]}, cyc: cyc + 1});
      drive(1'b1, p[7:0]);
      repeat ($urandom_range(0, 1)) drive(1'b0, 8'($urandom));
    end
    if (half) drive(1'b1, 8'($urandom));
    if (vs_mid) begin
      tick();
      vs_rise_ev();
      tick();
      cam_href = 1'b0;
      idle(3);
      vs_fall_ev();
      idle(3);
    end else begin
      cam_href = 1'b0;
      if (m_active && n > 0 && m_row < SY) m_row++;
      idle(2);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (addr_in !== '0 || data_in !== '0 || regwrite !== 1'b0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: addr=%0d data=%b we=%b done=%b, required all 0",
               name, addr_in, data_in, regwrite, frame_done);
    end
  endtask

  // Monitor: every write or frame_done the DUT presents is matched in order
  // against the scoreboard, including the cycle it appears in.
  exp_t e;
  always @(negedge clk) begin
    if (!rst && regwrite) begin
      vectors++;
      if (q.size() == 0 || q[0].done) begin
        miscompares++;
        $display("FAIL write: unexpected write addr=%0d data=%b cyc=%0d", addr_in, data_in, cyc);
      end else begin
        e = q.pop_front();
        if (addr_in !== e.addr || data_in !== e.data || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL write: got addr=%0d data=%b cyc=%0d, required addr=%0d data=%b cyc=%0d",
                   addr_in, data_in, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
    if (!rst && frame_done) begin
      vectors++;
      if (q.size() == 0 || !q[0].done) begin
        miscompares++;
        $display("FAIL frame_done: unexpected pulse at cyc=%0d", cyc);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc) begin
          miscompares++;
          $display("FAIL frame_done: got cyc=%0d, required cyc=%0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d expected events pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Stimulus before any vsync: nothing may be written.
    send_line(6, 1'b0, 1'b0, 16'h0, 1'b0);
    send_line(3, 1'b1, 1'b0, 16'h0, 1'b0);

    // Full frame of red pixels, closed by the next vsync rise.
    vsync_pulse();
    for (int l = 0; l < SY; l++) send_line(SX, 1'b0, 1'b1, 16'hF800, 1'b0);
    vsync_pulse();

    // Green single pixel, overlong lines, dangling byte on line 3, empty
    // line, and more lines than the frame holds.
    send_line(1, 1'b0, 1'b1, 16'h07E0, 1'b0);
    send_line(20, 1'b0, 1'b0, 16'h0, 1'b0);
    send_line(20, 1'b0, 1'b0, 16'h0, 1'b0);
    send_line(5, 1'b1, 1'b0, 16'h0, 1'b0);
    send_line(0, 1'b1, 1'b0, 16'h0, 1'b0);
    send_line(16, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int l = 5; l < 16; l++)
      send_line($urandom_range(1, 20), 1'($urandom), 1'b0, 16'h0, 1'b0);
    vsync_pulse();

    // vsync rises in the middle of line 7; the next frame restarts at 0.
    for (int l = 0; l < 7; l++) send_line(SX, 1'b0, 1'b0, 16'h0, 1'b0);
    send_line(3, 1'b1, 1'b0, 16'h0, 1'b1);
    for (int l = 0; l < 3; l++) send_line($urandom_range(0, 18), 1'($urandom), 1'b0, 16'h0, 1'b0);

    // Reset mid-frame with href high and a first byte pending.
    cam_href = 1'b1;
    tick();
    drive(1'b1, 8'hFF);
    rst = 1'b1;
    tick();
    check_reset_outputs("mid-frame reset");
    rst = 1'b0;
    m_active = 0;
    m_armed  = 0;
    drive(1'b1, 8'hFF);
    cam_href = 1'b0;
    idle(2);
    send_line(4, 1'b0, 1'b0, 16'h0, 1'b0);

    // Capture resumes only after a full vsync pulse.
    vsync_pulse();
    for (int l = 0; l < 4; l++) send_line($urandom_range(0, 20), 1'($urandom), 1'b0, 16'h0, 1'b0);
    vsync_pulse();
    idle(10);

    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected events never seen, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cam_frame_writer.md
# cam_frame_writer

Write-side front end of the VGA frame buffer: it accepts a camera-style RGB565 byte stream (vsync/href/byte strobe, already synchronous to `clk`) and reduces each pixel to RGB111. It then writes the pixels row-major into the write port of the dual-port buffer RAM (`addr_in`/`data_in`/`regwrite`), which the VGA read path scans out. One frame of `CAM_SCREEN_X` x `CAM_SCREEN_Y` pixels is written per vsync period; excess pixels and lines are discarded.

## Interface
- `AW`, 8, buffer address width; requires `CAM_SCREEN_X*CAM_SCREEN_Y <= 2**AW`
- `DW`, 3, buffer data width (RGB111, R in bit 2, B in bit 0)
- `CAM_SCREEN_X`, 16, pixels stored per line
- `CAM_SCREEN_Y`, 12, lines stored per frame

Ports:
- `clk` in 1 system clock (75 MHz domain); the only clock
- `rst` in 1 reset, synchronous and active-high
- `cam_vsync` in 1 frame sync, high between frames
- `cam_href` in 1 line valid, high while a line's bytes arrive
- `cam_de` in 1 byte strobe, one-cycle pulse per valid `cam_data` byte
- `cam_data` in 8 pixel byte; first byte is {R[4:0],G[5:3]}, second byte is {G[2:0],B[4:0]}
- `addr_in` out AW buffer write address
- `data_in` out DW buffer write data, RGB111
- `regwrite` out 1 buffer write enable, one-cycle pulse per stored pixel
- `frame_done` out 1 one-cycle pulse at the end of each captured frame

## Operation
- Registers: `state`, `x` (AW bits), `y` (AW bits), `phase` (byte 0/1), `byte0` (8 bits), `vsync_d`, `href_d`.
- Edges are computed from registered previous values: `vs_rise = cam_vsync & ~vsync_d`, `vs_fall`, `href_fall`.
- States:
  - `IDLE`: entered after reset. All camera input is ignored. On `vs_rise` -> `SYNC`.
  - `SYNC`: on `vs_fall`, clear `x`, `y` and `phase`, then -> `ACTIVE`.
  - `ACTIVE`: capture as described below. On `vs_rise`, pulse `frame_done` and -> `SYNC`.
- Capture in `ACTIVE`, on a cycle with `cam_de & cam_href`:
  - If `phase`=0: latch `byte0 <= cam_data` and set `phase <= 1`.
  - If `phase`=1: set `phase <= 0`. If `x < CAM_SCREEN_X` and `y < CAM_SCREEN_Y`, then on the next edge:
    - `data_in <= {byte0[7], byte0[2], cam_data[4]}` (R msb, G msb, B msb)
    - `addr_in <= x + y*CAM_SCREEN_X`, truncated to AW
    - `regwrite <= 1`
    - `x <= x + 1`
  - Otherwise the pixel is dropped and `x` saturates (no wrap).
- `cam_de` while `cam_href` is low is ignored in every state.
- On `href_fall` in `ACTIVE`: `phase <= 0`, so a dangling first byte is discarded. If at least one pixel was received on the line (`x != 0`, or the line counted as pixels), then `x <= 0` and `y <= y + 1`, with `y` saturating at `CAM_SCREEN_Y`. Lines with no bytes do not advance `y`.
- Lines beyond `CAM_SCREEN_Y` produce no writes. The frame ends only at `vs_rise`.

## Timing
- Reset values: `addr_in`=0, `data_in`=0, `regwrite`=0, `frame_done`=0, `state`=`IDLE`, and all counters 0.
- Write latency: `regwrite` is high in exactly the cycle after the clock edge that samples the second-byte `cam_de`.
- `addr_in`/`data_in` hold their values until the next write. `regwrite` never stays high for two consecutive cycles unless two second-bytes arrive on consecutive cycles.
- `frame_done` is high for the single cycle after the edge that detects `vs_rise` in `ACTIVE`. `vs_rise` in `SYNC` or `IDLE` does not pulse it.
- A `vs_rise` mid-line is handled as follows: any pending write still completes, the half pixel is dropped, `frame_done` pulses, and the partial frame is left in RAM.
- If `href_fall` and a second-byte `cam_de` occur in the same cycle, the write is issued using the current `x`/`y`, and the counters then advance to the new line.
- `rst` asserted mid-frame: all outputs return to reset values on the next edge, and capture resumes only after a complete `vs_rise` then `vs_fall` sequence.
- Arithmetic: `y*CAM_SCREEN_X` uses a full-width product, then is truncated to AW. The address never exceeds `CAM_SCREEN_X*CAM_SCREEN_Y-1`.

## Test plan
- **Reset, then one full 16x12 frame of pixels 0xF800 (red).** Required: 192 `regwrite` pulses at addresses 0..191 in order, each with `data_in`=3'b100. Then one `frame_done` on the next vsync rise.
- **Single pixel, bytes 0x07 then 0xE0 (green).** Required: `data_in`=3'b010, and `regwrite` is high exactly one cycle after the second `cam_de`.
- **Line of 20 pixels, then 14 lines.** Required: `x` stops at 16 with no writes for pixels 16..19, lines 12..13 produce no writes, and the highest address written is 191.
- **`href` drops after the first byte of pixel 5 on line 3.** Required: no write for that pixel, and the next line's first write goes to address 64.
- **Stimulus before the first vsync, and pixels plus `rst` pulsed mid-frame.** Required: no `regwrite` until a vsync rise/fall pair is seen, and all outputs are 0 the cycle after `rst`.
- **`vsync` rises mid-line 7.** Required: a single `frame_done` pulse, and the next frame restarts at address 0.
